// File: rtl/mips_debug_unit.sv
// Host debug controller for the MIPS pipeline.
// An on-board UART (8 data bits, even parity, 1 stop bit) carries host
// commands that load instruction memory word by word, start the core in
// continuous or single-step mode, and return the 32-bit PC to the host.
module mips_debug_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int CLKS_PER_BIT    = 64
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_finish,
  input  logic                  i_rx_data,
  input  logic                  i_parity,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic                  o_parity,
  output logic                  o_tx_data,
  output logic                  o_tx_done,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic                  o_loading,
  output logic                  o_start,
  output logic                  o_step
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH_UART);
  localparam int BYTES = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int IDX_W = $clog2(BYTES);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH_UART - 1);
  localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(BYTES - 1);

  localparam logic [DATA_WIDTH_UART-1:0] CMD_LOAD      = DATA_WIDTH_UART'(8'hFF);
  localparam logic [DATA_WIDTH_UART-1:0] CMD_RUN       = DATA_WIDTH_UART'(8'h0F);
  localparam logic [DATA_WIDTH_UART-1:0] CMD_STEP_MODE = DATA_WIDTH_UART'(8'hFF);
  localparam logic [DATA_WIDTH_UART-1:0] CMD_STEP      = DATA_WIDTH_UART'(8'hAA);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_MODE, ST_RUN, ST_STEP_WAIT, ST_SEND_PC
  } state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // Host-side parity flag is accepted but has no functional effect.
  logic w_unused_parity;
  assign w_unused_parity = i_parity;

  // ---------------------------------------------------------------- RX
  logic [1:0]                 r_rx_sync;
  logic                       w_rx;
  rx_state_t                  r_rx_state, w_rx_next;
  logic [CNT_W-1:0]           r_rx_cnt;
  logic [BIT_W-1:0]           r_rx_bit;
  logic [DATA_WIDTH_UART-1:0] r_rx_shift;
  logic                       r_rx_par;
  logic                       r_rx_valid;
  logic                       r_parity;
  logic                       w_rx_tick;
  logic                       w_rx_par_err;

  // Two-flop synchronizer for the asynchronous host line; idles high.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_rx_sync <= 2'b11;
    else          r_rx_sync <= {r_rx_sync[0], i_rx_data};
  end

  assign w_rx         = r_rx_sync[1];
  // Start bit is checked half a bit in; from then on every full bit lands mid-bit.
  assign w_rx_tick    = (r_rx_state == RX_START) ? (r_rx_cnt == HALF_LAST)
                                                 : (r_rx_cnt == BIT_LAST);
  assign w_rx_par_err = ^{r_rx_shift, r_rx_par};

  // RX next-state: frame walk, aborting on a start bit that does not hold.
  // NOTE: the default is assigned first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (!w_rx) w_rx_next = RX_START;
      RX_START:  if (w_rx_tick) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_tick && r_rx_bit == DATA_LAST) w_rx_next = RX_PARITY;
      RX_PARITY: if (w_rx_tick) w_rx_next = RX_STOP;
      RX_STOP:   if (w_rx_tick) w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: bit timing, LSB-first shift, parity and stop validation.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_valid <= 1'b0;
      if (r_rx_state == RX_IDLE || w_rx_tick) r_rx_cnt <= '0;
      else                                    r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_rx_tick) begin
        case (r_rx_state)
          RX_START:  r_rx_bit <= '0;
          RX_DATA: begin
            r_rx_shift <= {w_rx, r_rx_shift[DATA_WIDTH_UART-1:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
          end
          RX_PARITY: r_rx_par <= w_rx;
          RX_STOP: begin
            r_parity   <= w_rx_par_err;
            r_rx_valid <= w_rx & ~w_rx_par_err;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_t                  r_tx_state, w_tx_next;
  logic [CNT_W-1:0]           r_tx_cnt;
  logic [BIT_W-1:0]           r_tx_bit;
  logic [DATA_WIDTH_UART-1:0] r_tx_shift;
  logic                       r_tx_par;
  logic                       r_tx_line;
  logic                       r_tx_done;
  logic                       w_tx_tick;
  logic                       w_tx_start;
  logic [DATA_WIDTH_UART-1:0] w_tx_byte;

  assign w_tx_tick = (r_tx_cnt == BIT_LAST);

  // TX next-state: start, data, parity, stop, each one bit period long.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:   if (w_tx_start) w_tx_next = TX_START;
      TX_START:  if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:   if (w_tx_tick && r_tx_bit == DATA_LAST) w_tx_next = TX_PARITY;
      TX_PARITY: if (w_tx_tick) w_tx_next = TX_STOP;
      TX_STOP:   if (w_tx_tick) w_tx_next = TX_IDLE;
      default:   w_tx_next = TX_IDLE;
    endcase
  end

  // TX datapath: registered line output, done pulse after the stop bit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_done  <= 1'b0;
      if (r_tx_state == TX_IDLE) begin
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
        if (w_tx_start) begin
          r_tx_shift <= w_tx_byte;
          r_tx_par   <= ^w_tx_byte;
          r_tx_line  <= 1'b0;
        end
      end else if (w_tx_tick) begin
        r_tx_cnt <= '0;
        case (r_tx_state)
          TX_START: r_tx_line <= r_tx_shift[0];
          TX_DATA: begin
            if (r_tx_bit == DATA_LAST) begin
              r_tx_line <= r_tx_par;
            end else begin
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_line  <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 1'b1;
            end
          end
          TX_PARITY: r_tx_line <= 1'b1;
          TX_STOP:   r_tx_done <= 1'b1;
          default: ;
        endcase
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------ command FSM
  state_t                r_state, w_next_state;
  logic [IDX_W-1:0]      r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_addr_out;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc_cap;
  logic [IDX_W-1:0]      r_tx_idx;
  logic                  r_tx_armed;
  logic                  r_loading;
  logic                  r_start;
  logic                  r_step;
  logic                  r_step_pending;
  logic [DATA_WIDTH-1:0] w_word_next;
  logic                  w_last_byte;
  logic                  w_step_fire;
  logic                  w_pc_done;

  // Little-endian assembly: each new byte enters at the top and shifts down.
  assign w_word_next = {r_rx_shift, r_word[DATA_WIDTH-1:DATA_WIDTH_UART]};
  assign w_last_byte = (r_byte_cnt == BYTE_LAST);
  assign w_step_fire = (r_state == ST_STEP_WAIT) && !r_step_pending && !i_finish &&
                       r_rx_valid && (r_rx_shift == CMD_STEP);
  assign w_pc_done   = (r_state == ST_SEND_PC) && r_tx_done && (r_tx_idx == BYTE_LAST);
  assign w_tx_start  = (r_state == ST_SEND_PC) && r_tx_armed && (r_tx_state == TX_IDLE);

  // Select the captured-PC byte for the frame being sent, lowest first.
  always_comb begin
    w_tx_byte = r_pc_cap[DATA_WIDTH_UART-1:0];
    for (int i = 0; i < BYTES; i++)
      if (r_tx_idx == IDX_W'(i)) w_tx_byte = r_pc_cap[i*DATA_WIDTH_UART +: DATA_WIDTH_UART];
  end

  // Command FSM next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (r_rx_valid && r_rx_shift == CMD_LOAD) w_next_state = ST_LOAD;
      ST_LOAD: if (r_rx_valid && w_last_byte && w_word_next == '0) w_next_state = ST_MODE;
      ST_MODE: begin
        if (r_rx_valid) begin
          if (r_rx_shift == CMD_RUN)            w_next_state = ST_RUN;
          else if (r_rx_shift == CMD_STEP_MODE) w_next_state = ST_STEP_WAIT;
        end
      end
      ST_RUN:       if (i_finish) w_next_state = ST_SEND_PC;
      ST_STEP_WAIT: if (r_step_pending || i_finish) w_next_state = ST_SEND_PC;
      ST_SEND_PC:   if (w_pc_done) w_next_state = i_finish ? ST_IDLE : ST_STEP_WAIT;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Command FSM state register and the datapath it steers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= ST_IDLE;
      r_byte_cnt     <= '0;
      r_word         <= '0;
      r_addr         <= '0;
      r_addr_out     <= '0;
      r_instr        <= '0;
      r_pc_cap       <= '0;
      r_tx_idx       <= '0;
      r_tx_armed     <= 1'b0;
      r_loading      <= 1'b0;
      r_start        <= 1'b0;
      r_step         <= 1'b0;
      r_step_pending <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_loading <= 1'b0;
      r_step    <= 1'b0;

      // PC is captured on entry to SEND_PC; the step pulse has already ended.
      if (w_next_state == ST_SEND_PC && r_state != ST_SEND_PC) begin
        r_pc_cap       <= i_pc;
        r_tx_idx       <= '0;
        r_tx_armed     <= 1'b1;
        r_step_pending <= 1'b0;
      end
      if (w_tx_start) r_tx_armed <= 1'b0;
      if (r_state == ST_SEND_PC && r_tx_done && !w_pc_done) begin
        r_tx_idx   <= r_tx_idx + 1'b1;
        r_tx_armed <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_rx_valid && r_rx_shift == CMD_LOAD) begin
            r_addr     <= '0;
            r_byte_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (r_rx_valid) begin
            r_word     <= w_word_next;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (w_last_byte) begin
              r_instr    <= w_word_next;
              r_addr_out <= r_addr;
              r_addr     <= r_addr + DATA_WIDTH'(BYTES);
              r_loading  <= 1'b1;
            end
          end
        end
        ST_MODE:      if (w_next_state != ST_MODE) r_start <= 1'b1;
        ST_STEP_WAIT: begin
          if (w_step_fire) begin
            r_step         <= 1'b1;
            r_step_pending <= 1'b1;
          end
        end
        ST_SEND_PC:   if (w_pc_done && i_finish) r_start <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_parity      = r_parity;
  assign o_tx_data     = r_tx_line;
  assign o_tx_done     = r_tx_done;
  assign o_instruccion = r_instr;
  assign o_address     = r_addr_out;
  assign o_loading     = r_loading;
  assign o_start       = r_start;
  assign o_step        = r_step;

endmodule

// File: tb/tb_mips_debug_unit.sv
// Scoreboard bench for mips_debug_unit: expected memory writes and PC
// bytes are queued as commands are sent and popped by the monitors.
module tb_mips_debug_unit;

  localparam int CLKS = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } load_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        finish;
  logic        rx_line;
  logic        host_parity;
  logic [31:0] pc;
  logic        o_parity, o_tx_data, o_tx_done, o_loading, o_start, o_step;
  logic [31:0] o_instruccion, o_address;

  load_t       exp_loads[$];
  logic [7:0]  exp_tx[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_loads  = 0;
  int          n_steps  = 0;

  mips_debug_unit #(.DATA_WIDTH(32), .DATA_WIDTH_UART(8), .CLKS_PER_BIT(CLKS)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_finish      (finish),
    .i_rx_data     (rx_line),
    .i_parity      (host_parity),
    .i_pc          (pc),
    .o_parity      (o_parity),
    .o_tx_data     (o_tx_data),
    .o_tx_done     (o_tx_done),
    .o_instruccion (o_instruccion),
    .o_address     (o_address),
    .o_loading     (o_loading),
    .o_start       (o_start),
    .o_step        (o_step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drive one host frame; bad_par flips the parity bit.
  task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0);
    logic [10:0] frame;
    frame = {1'b1, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_line = frame[i];
      repeat (CLKS) @(negedge clk);
    end
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic expect_load(input logic [31:0] instr, input logic [31:0] addr);
    load_t l;
    l.instr = instr;
    l.addr  = addr;
    exp_loads.push_back(l);
  endtask

  task automatic expect_pc(input logic [31:0] v);
    for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
  endtask

  task automatic wait_tx_drain();
    int k;
    k = 0;
    while (exp_tx.size() != 0 && k < 6 * 11 * CLKS) begin
      @(negedge clk);
      k++;
    end
    check("tx_drain", exp_tx.size(), 0);
    repeat (2 * CLKS) @(negedge clk);
  endtask

  // Memory-write and step monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_loading) begin
        load_t l;
        n_loads++;
        check("no_step_with_load", o_step, 0);
        check("load_expected", exp_loads.size() != 0, 1);
        if (exp_loads.size() != 0) begin
          l = exp_loads.pop_front();
          check("load_instr", o_instruccion, l.instr);
          check("load_addr", o_address, l.addr);
        end
      end
      if (o_step) begin
        n_steps++;
        check("step_while_started", o_start, 1);
      end
    end
  end

  // Host-side UART receiver for the PC frames.
  initial begin
    logic [7:0] b, e;
    logic       pbit, sbit;
    bit         seen;
    forever begin
      @(negedge clk);
      if (rst_n && o_tx_data == 1'b0) begin
        repeat (CLKS / 2) @(negedge clk);
        check("tx_start_bit", o_tx_data, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKS) @(negedge clk);
          b[i] = o_tx_data;
        end
        repeat (CLKS) @(negedge clk);
        pbit = o_tx_data;
        repeat (CLKS) @(negedge clk);
        sbit = o_tx_data;
        check("tx_frame_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          check("tx_byte", b, e);
        end
        check("tx_parity", pbit, ^b);
        check("tx_stop", sbit, 1);
        seen = 1'b0;
        for (int k = 0; k < CLKS && !seen; k++) begin
          @(negedge clk);
          if (o_tx_done) seen = 1'b1;
        end
        check("tx_done_pulse", seen, 1);
        @(negedge clk);
        check("tx_done_width", o_tx_done, 0);
      end
    end
  end

  initial begin
    rx_line     = 1'b1;
    finish      = 1'b0;
    host_parity = 1'b0;
    pc          = '0;
    rst_n       = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_outputs", {o_parity, o_tx_data, o_tx_done, o_loading, o_start, o_step}, 6'b010000);
    rst_n = 1'b1;

    // Idle line after reset: nothing moves.
    repeat (1000) @(negedge clk);
    check("idle_outputs", {o_parity, o_tx_data, o_tx_done, o_loading, o_start, o_step}, 6'b010000);
    check("idle_instr", o_instruccion, 0);
    check("idle_addr", o_address, 0);
    check("idle_loads", n_loads, 0);

    // Non-load byte in IDLE is ignored; then load the first word.
    send_byte(8'h0F);
    send_byte(8'hFF);
    expect_load(32'h00040302, 32'h0);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h00);
    check("load1_count", n_loads, 1);

    // End-of-program marker is still written, then MODE.
    expect_load(32'h0, 32'h4);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("load2_count", n_loads, 2);
    check("mode_not_started", o_start, 0);

    // Single-step mode, one step, PC returned LSB first.
    pc = 32'h80E17021;
    send_byte(8'hFF);
    check("step_mode_start", o_start, 1);
    check("no_step_yet", n_steps, 0);
    expect_pc(32'h80E17021);
    send_byte(8'hAA);
    wait_tx_drain();
    check("one_step", n_steps, 1);
    check("still_started", o_start, 1);

    // Finish while waiting for a step: PC sent again, core stopped.
    pc = 32'h1234ABCD;
    expect_pc(32'h1234ABCD);
    finish = 1'b1;
    wait_tx_drain();
    check("stopped_after_finish", o_start, 0);
    finish = 1'b0;

    // Short glitch on the idle line must not start a frame.
    rx_line = 1'b0;
    repeat (8) @(negedge clk);
    rx_line = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    check("glitch_parity", o_parity, 0);

    // Reload at address 0 with one corrupted frame dropped.
    send_byte(8'hFF);
    expect_load(32'h44332211, 32'h0);
    send_byte(8'h11);
    send_byte(8'h55, 1'b1);
    check("bad_parity_flag", o_parity, 1);
    send_byte(8'h22);
    check("good_parity_flag", o_parity, 0);
    send_byte(8'h33);
    send_byte(8'h44);
    check("load3_count", n_loads, 3);

    // Zero word then continuous run until finish.
    expect_load(32'h0, 32'h4);
    repeat (4) send_byte(8'h00);
    send_byte(8'h0F);
    check("run_start", o_start, 1);
    pc = 32'hDEADBEEF;
    expect_pc(32'hDEADBEEF);
    finish = 1'b1;
    wait_tx_drain();
    check("run_stopped", o_start, 0);
    check("steps_total", n_steps, 1);
    finish = 1'b0;

    check("loads_total", n_loads, 4);
    check("load_queue_empty", exp_loads.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
- Host-facing debug controller for the MIPS pipeline.
- Contains its own serial UART (8 data bits, even parity, 1 stop bit).
- Decodes host commands to load instruction memory word by word, then starts the processor in either continuous or single-step mode.
- Returns the 32-bit PC to the host over the serial line.

Parameters:
- DATA_WIDTH, 32, width of instruction, address and PC words.
- DATA_WIDTH_UART, 8, UART data bits per frame.
- CLKS_PER_BIT, 64, i_clock cycles per serial bit.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_finish  in  1  processor reached end of program (level).
- i_rx_data  in  1  serial line from host (idle high).
- i_parity  in  1  host-side parity-error flag; sampled, no functional effect.
- i_pc  in  DATA_WIDTH  current processor PC.
- o_parity  out  1  parity-error flag of the last received frame.
- o_tx_data  out  1  serial line to host (idle high).
- o_tx_done  out  1  one-cycle pulse at the end of each transmitted frame.
- o_instruccion  out  DATA_WIDTH  assembled instruction word.
- o_address  out  DATA_WIDTH  byte address for o_instruccion.
- o_loading  out  1  one-cycle write strobe for instruction memory.
- o_start  out  1  processor enable (level).
- o_step  out  1  one-cycle single-step pulse.

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs 0 except o_tx_data=1; FSM to IDLE; byte counter 0; address 0; UART RX/TX idle.
- Serial frame format:
  - start bit 0, then 8 data bits LSB first, then even parity bit, then stop bit 1;
  - each bit lasts CLKS_PER_BIT cycles, so one frame = 11*CLKS_PER_BIT cycles.
- RX:
  - Falling edge on the idle line starts a frame.
  - Start bit is re-checked at mid-bit; if high, abort and return to idle.
  - Data bits are sampled at mid-bit.
  - Parity mismatch: o_parity=1 and the byte is discarded. Otherwise o_parity=0 and a byte-valid pulse goes to the FSM.
  - Missing stop bit: the byte is discarded.
- TX: loads a byte when idle, sends the full frame, pulses o_tx_done for 1 cycle after the stop bit.
- FSM states: IDLE, LOAD, MODE, RUN, STEP_WAIT, SEND_PC.
- IDLE:
  - byte 0xFF: address:=0, go to LOAD.
  - any other byte is ignored.
- LOAD:
  - Bytes are assembled little-endian: the first byte received is bits[7:0].
  - After the 4th byte: o_instruccion=word and o_address=current address, held stable; o_loading=1 for exactly 1 cycle the next clock; address+=4.
  - An all-zero word is still written (end-of-program marker), then the FSM goes to MODE.
- MODE:
  - byte 0x0F: o_start=1, go to RUN.
  - byte 0xFF: o_start=1, go to STEP_WAIT.
  - other bytes ignored.
- RUN: when i_finish=1, go to SEND_PC.
- STEP_WAIT:
  - byte 0xAA: o_step pulses 1 cycle, then go to SEND_PC after 1 cycle, capturing i_pc.
  - i_finish=1 while no step is pending: go to SEND_PC.
  - other bytes ignored.
- SEND_PC:
  - Sends the captured PC as 4 frames, bytes [7:0], [15:8], [23:16], [31:24], back-to-back, each started after the previous o_tx_done.
  - Afterwards: if i_finish=1, o_start=0 and go to IDLE; otherwise return to STEP_WAIT.
- Bytes received while in SEND_PC are dropped.
- o_step and o_loading never overlap.
- Reset in mid-frame aborts RX/TX immediately; the line returns high.

Test Plan:
- Reset released, line idle for 1000 cycles -> all outputs 0, o_tx_data=1, no o_loading.
- Send 0xFF, then bytes 0x02,0x03,0x04,0x00 -> one o_loading pulse with o_instruccion=0x00040302 and o_address=0.
- Send 0x00 x4 next -> o_loading with o_instruccion=0, o_address=4; FSM in MODE, o_start still 0.
- Send 0xFF, then 0xAA, with i_pc=0x80E17021 -> o_start=1, one o_step pulse, then host receives 0x21, 0x70, 0xE1, 0x80, each followed by an o_tx_done pulse.
- Raise i_finish -> after the PC bytes, o_start=0 and the FSM accepts 0xFF to reload at address 0.
- Send a frame with wrong parity during LOAD -> o_parity=1, byte not counted; the next 4 good bytes form the word.
